// File: rtl/player_input_ctrl.sv
// Two-player button conditioning: 2-flop sync, counter debounce, last-pressed-wins
// direction arbitration and fire pulses with optional auto-repeat, all gated by game_on.
module player_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTOFIRE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_on,
  input  logic [4:0] btn1,
  input  logic [4:0] btn2,
  output logic       up1,
  output logic       down1,
  output logic       left1,
  output logic       right1,
  output logic       fire1,
  output logic       up2,
  output logic       down2,
  output logic       left2,
  output logic       right2,
  output logic       fire2
);

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  // A period of 1 would give back-to-back pulses, so repeat never runs faster than every 2 cycles.
  localparam int unsigned AF_PERIOD = (AUTOFIRE_CYCLES < 2) ? 2 : AUTOFIRE_CYCLES;
  localparam logic [23:0] AF_LAST   = 24'(AF_PERIOD - 1);
  localparam bit          AF_EN     = (AUTOFIRE_CYCLES != 0);

  logic [9:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [9:0]  deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [19:0] cnt_q [10];
  logic [19:0] cnt_d [10];
  logic [2:0]  dir_sel_q [2];
  logic [2:0]  dir_sel_d [2];
  logic [23:0] rep_q [2];
  logic [23:0] rep_d [2];
  logic [1:0]  arm_q, arm_d;
  logic [4:0]  out_q [2];
  logic [4:0]  out_d [2];
  logic [4:0]  held [2];
  logic [4:0]  rise [2];
  logic [1:0]  pulse;

  // dirs = {up, down, left, right}
  function automatic logic [2:0] pick_dir(input logic [3:0] dirs);
    if (dirs[3])      return DIR_UP;
    else if (dirs[2]) return DIR_DOWN;
    else if (dirs[1]) return DIR_LEFT;
    else if (dirs[0]) return DIR_RIGHT;
    else              return DIR_NONE;
  endfunction

  function automatic logic dir_held(input logic [2:0] sel, input logic [3:0] dirs);
    case (sel)
      DIR_UP:    return dirs[3];
      DIR_DOWN:  return dirs[2];
      DIR_LEFT:  return dirs[1];
      DIR_RIGHT: return dirs[0];
      default:   return 1'b0;
    endcase
  endfunction

  always_comb begin
    sync1_d    = {btn2, btn1};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int unsigned i = 0; i < 10; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end

    for (int unsigned p = 0; p < 2; p++) begin
      held[p] = deb_q[p*5 +: 5];
      rise[p] = held[p] & ~deb_prev_q[p*5 +: 5];

      // NONE with buttons held (after game_on rises) re-arbitrates by priority.
      dir_sel_d[p] = dir_sel_q[p];
      if (!game_on)
        dir_sel_d[p] = DIR_NONE;
      else if (rise[p][4:1] != '0)
        dir_sel_d[p] = pick_dir(rise[p][4:1]);
      else if (!dir_held(dir_sel_q[p], held[p][4:1]))
        dir_sel_d[p] = pick_dir(held[p][4:1]);

      // arm_q marks a press that pulsed while enabled; only an armed hold may repeat.
      pulse[p] = 1'b0;
      arm_d[p] = arm_q[p];
      rep_d[p] = '0;
      if (!game_on || !held[p][0]) begin
        arm_d[p] = 1'b0;
      end else if (rise[p][0]) begin
        pulse[p] = 1'b1;
        arm_d[p] = 1'b1;
      end else if (AF_EN && arm_q[p]) begin
        if (rep_q[p] == AF_LAST) pulse[p] = 1'b1;
        else                     rep_d[p] = rep_q[p] + 24'd1;
      end

      out_d[p] = {dir_sel_d[p] == DIR_UP, dir_sel_d[p] == DIR_DOWN,
                  dir_sel_d[p] == DIR_LEFT, dir_sel_d[p] == DIR_RIGHT, pulse[p]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      arm_q      <= '0;
      for (int unsigned i = 0; i < 10; i++) cnt_q[i] <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        dir_sel_q[p] <= DIR_NONE;
        rep_q[p]     <= '0;
        out_q[p]     <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      arm_q      <= arm_d;
      for (int unsigned i = 0; i < 10; i++) cnt_q[i] <= cnt_d[i];
      for (int unsigned p = 0; p < 2; p++) begin
        dir_sel_q[p] <= dir_sel_d[p];
        rep_q[p]     <= rep_d[p];
        out_q[p]     <= out_d[p];
      end
    end
  end

  assign up1    = out_q[0][4];
  assign down1  = out_q[0][3];
  assign left1  = out_q[0][2];
  assign right1 = out_q[0][1];
  assign fire1  = out_q[0][0];
  assign up2    = out_q[1][4];
  assign down2  = out_q[1][3];
  assign left2  = out_q[1][2];
  assign right2 = out_q[1][1];
  assign fire2  = out_q[1][0];

endmodule
